// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: one-hot row strobe, 2-flop column synchroniser,
// per-key debounce, press events queued in a first-word-fall-through FIFO.
module keypad_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic [COLS-1:0]               col,
    output logic [ROWS-1:0]               row,
    output logic [ROWS*COLS-1:0]          key_state,
    output logic                          key_valid,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    input  logic                          key_rd,
    output logic                          irq,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int NK   = ROWS * COLS;
    localparam int KW   = $clog2(NK);
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNTW = $clog2(SCAN_DIV);
    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int FCW  = AW + 1;

    logic [COLS-1:0]          col_s1_q, col_s2_q;
    logic [CNTW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]            r_q, r_d;
    logic [ROWS-1:0]          row_q, row_d;
    logic [NK-1:0]            key_state_q;
    logic [NK-1:0][DBW-1:0]   db_q;
    logic [KW-1:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wp_q, rp_q;
    logic [FCW-1:0]           fcnt_q;
    logic                     ovf_q;

    logic                     ev, smp, cur, flip, push, pop, full, do_push, ovf_evt;
    logic [CW-1:0]            c_idx;
    logic [KW-1:0]            k_idx;
    logic [DBW-1:0]           dbc;

    // Two-flop synchroniser for the asynchronous column inputs
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            col_s1_q <= '0;
            col_s2_q <= '0;
        end else begin
            col_s1_q <= col;
            col_s2_q <= col_s1_q;
        end
    end

    // Dwell counter and row advance; row strobe is registered with the index
    always_comb begin
        cnt_d = cnt_q + CNTW'(1);
        r_d   = r_q;
        if (cnt_q == CNTW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            r_d   = (r_q == RW'(ROWS - 1)) ? '0 : r_q + RW'(1);
        end
        row_d = ROWS'(1) << r_d;
    end

    // Scan state register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
            r_q   <= '0;
            row_q <= ROWS'(1);
        end else begin
            cnt_q <= cnt_d;
            r_q   <= r_d;
            row_q <= row_d;
        end
    end

    // Pick the single key evaluated this clock (last COLS counts of a dwell)
    // and decide whether its stable state flips
    always_comb begin
        ev    = (cnt_q >= CNTW'(SCAN_DIV - COLS));
        c_idx = ev ? CW'(cnt_q - CNTW'(SCAN_DIV - COLS)) : '0;
        k_idx = KW'(32'(r_q) * COLS + 32'(c_idx));
        smp   = col_s2_q[c_idx];
        cur   = key_state_q[k_idx];
        dbc   = db_q[k_idx];
        flip  = ev && (smp != cur) && (dbc == DBW'(DEBOUNCE - 1));
        push  = flip && smp;
    end

    // Per-key debounce: count consecutive disagreeing visits, flip at DEBOUNCE
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            key_state_q <= '0;
            db_q        <= '0;
        end else if (ev) begin
            if (smp == cur) begin
                db_q[k_idx] <= '0;
            end else if (flip) begin
                db_q[k_idx]        <= '0;
                key_state_q[k_idx] <= smp;
            end else begin
                db_q[k_idx] <= dbc + DBW'(1);
            end
        end
    end

    // FIFO control: a pop frees a slot so a push into a full queue still lands
    always_comb begin
        pop     = key_rd && (fcnt_q != '0);
        full    = (fcnt_q == FCW'(FIFO_DEPTH));
        do_push = push && (!full || pop);
        ovf_evt = push && full && !pop;
    end

    // FIFO storage and pointers (storage needs no reset; output is gated)
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= k_idx;
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear)
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (pop)     rp_q <= rp_q + AW'(1);
            fcnt_q <= fcnt_q + FCW'(do_push) - FCW'(pop);
            if (ovf_evt)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign row       = row_q;
    assign key_state = key_state_q;
    assign key_valid = (fcnt_q != '0);
    assign key_code  = key_valid ? mem_q[rp_q] : '0;
    assign irq       = key_valid;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a 4x4 keypad model.
module tb_keypad_scan_fifo;
    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_state;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_rd = 1'b0;
    logic        irq;
    logic        overflow;
    logic        ovf_clr = 1'b0;

    logic [3:0]  mask [4];
    int          checks = 0;
    int          errors = 0;

    keypad_scan_fifo #(
        .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .RST(RST), .col(col), .row(row), .key_state(key_state),
        .key_valid(key_valid), .key_code(key_code), .key_rd(key_rd),
        .irq(irq), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Keypad model: a row's mask appears on col while that row is strobed
    always_comb begin
        col = 4'b0;
        for (int r = 0; r < 4; r++)
            if (row[r]) col = col | mask[r];
    end

    task automatic pulse_rd();
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
    endtask

    task automatic press(input int r, input int c);
        mask[r] = 4'(1 << c);
        repeat (96) @(negedge clk);
        mask[r] = 4'b0;
        repeat (96) @(negedge clk);
    endtask

    task automatic wait_row(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (row === target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int r = 0; r < 4; r++) mask[r] = 4'b0;
        RST = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (row !== 4'b0001 || key_valid !== 1'b0 || overflow !== 1'b0 ||
            irq !== 1'b0 || key_state !== 16'h0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset: row=%b valid=%b ovf=%b irq=%b state=%h code=%h required 0001 0 0 0 0000 0",
                     row, key_valid, overflow, irq, key_state, key_code);
        end
        RST = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] exp_row;
        for (int s = 0; s < 5; s++) begin
            exp_row = 4'(1 << (s % 4));
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (row !== exp_row) begin
                    errors++;
                    $display("FAIL scan step %0d cyc %0d: row=%b required %b", s, j, row, exp_row);
                end
                @(negedge clk);
            end
        end
        // now at the start of row 1's dwell; reset three clocks in
        repeat (3) @(negedge clk);
        #2 RST = 1'b1;
        #1;
        checks++;
        if (row !== 4'b0001 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid-dwell reset: row=%b valid=%b required 0001 0", row, key_valid);
        end
        @(negedge clk);
        RST = 1'b0;
    endtask

    // Starts on the negedge where reset was released: r1c0 is evaluated on
    // the 13th and 45th rising edges, so the push lands on edge 45.
    task automatic test_single_press();
        mask[1] = 4'b0001;
        repeat (44) @(negedge clk);
        checks++;
        if (key_valid !== 1'b0 || key_state[4] !== 1'b0) begin
            errors++;
            $display("FAIL press early: valid=%b state4=%b required 0 0", key_valid, key_state[4]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (key_state !== 16'h0010 || key_valid !== 1'b1 || key_code !== 4'd4 || irq !== 1'b1) begin
            errors++;
            $display("FAIL press: state=%h valid=%b code=%0d irq=%b required 0010 1 4 1",
                     key_state, key_valid, key_code, irq);
        end
        pulse_rd();
        checks++;
        if (key_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL press pop: valid=%b irq=%b required 0 0", key_valid, irq);
        end
        repeat (320) @(negedge clk);
        checks++;
        if (key_valid !== 1'b0 || key_state[4] !== 1'b1) begin
            errors++;
            $display("FAIL hold: valid=%b state4=%b required 0 1", key_valid, key_state[4]);
        end
        mask[1] = 4'b0;
        repeat (96) @(negedge clk);
        checks++;
        if (key_state !== 16'h0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: state=%h valid=%b required 0000 0", key_state, key_valid);
        end
    endtask

    task automatic test_glitch();
        bit ok1, ok2, ok3;
        wait_row(4'b0100, ok1);
        wait_row(4'b1000, ok2);
        mask[3] = 4'b0100;
        wait_row(4'b0001, ok3);
        mask[3] = 4'b0;
        checks++;
        if (!(ok1 && ok2 && ok3)) begin
            errors++;
            $display("FAIL glitch row wait: timeout ok=%b%b%b required 111", ok1, ok2, ok3);
        end
        repeat (96) @(negedge clk);
        checks++;
        if (key_state !== 16'h0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch: state=%h valid=%b required 0000 0", key_state, key_valid);
        end
    endtask

    task automatic test_same_row();
        mask[2] = 4'b1010;
        repeat (96) @(negedge clk);
        checks++;
        if (key_state !== 16'h0A00) begin
            errors++;
            $display("FAIL pair state: state=%h required 0a00", key_state);
        end
        mask[2] = 4'b0;
        repeat (96) @(negedge clk);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd9) begin
            errors++;
            $display("FAIL pair first: valid=%b code=%0d required 1 9", key_valid, key_code);
        end
        pulse_rd();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd11) begin
            errors++;
            $display("FAIL pair second: valid=%b code=%0d required 1 11", key_valid, key_code);
        end
        pulse_rd();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL pair empty: valid=%b required 0", key_valid);
        end
    endtask

    task automatic test_overflow();
        press(0, 0); press(0, 1); press(0, 2); press(0, 3); press(1, 1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow set: overflow=%b required 1", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (key_valid !== 1'b1 || key_code !== 4'(i)) begin
                errors++;
                $display("FAIL overflow pop %0d: valid=%b code=%0d required 1 %0d", i, key_valid, key_code, i);
            end
            pulse_rd();
        end
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow drained: valid=%b required 0", key_valid);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow clear: overflow=%b required 0", overflow);
        end
    endtask

    // From the first negedge of a row-3 dwell, r3c0 is evaluated on the 5th
    // and 37th rising edges; key_rd is held across the 37th.
    task automatic test_push_pop();
        bit ok1, ok2;
        logic [3:0] exp_codes [4];
        exp_codes[0] = 4'd7; exp_codes[1] = 4'd8; exp_codes[2] = 4'd10; exp_codes[3] = 4'd12;
        press(1, 2); press(1, 3); press(2, 0); press(2, 2);
        wait_row(4'b0100, ok1);
        wait_row(4'b1000, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL push/pop row wait: timeout ok=%b%b required 11", ok1, ok2);
        end
        mask[3] = 4'b0001;
        repeat (36) @(negedge clk);
        pulse_rd();
        checks++;
        if (overflow !== 1'b0 || key_valid !== 1'b1 || key_state[12] !== 1'b1) begin
            errors++;
            $display("FAIL push/pop: ovf=%b valid=%b state12=%b required 0 1 1",
                     overflow, key_valid, key_state[12]);
        end
        mask[3] = 4'b0;
        repeat (96) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (key_valid !== 1'b1 || key_code !== exp_codes[i]) begin
                errors++;
                $display("FAIL push/pop drain %0d: valid=%b code=%0d required 1 %0d",
                         i, key_valid, key_code, exp_codes[i]);
            end
            pulse_rd();
        end
        checks++;
        if (key_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL push/pop end: valid=%b ovf=%b required 0 0", key_valid, overflow);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan();
        test_single_press();
        test_glitch();
        test_same_row();
        test_overflow();
        test_push_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Parametrised matrix-keypad scanner for the Cortex-M0 SoC peripheral set; successor to the fixed 4-column key input that feeds the waterlight demo.
- Drives one-hot row strobes, samples column inputs and debounces every key independently.
- Queues press events as key codes in a first-word-fall-through FIFO that the processor drains with a read strobe.
- Provides interrupt and overflow status.

Parameters:
ROWS, 4, number of keypad rows (>=2)
COLS, 4, number of keypad columns (>=1)
SCAN_DIV, 1000, clocks each row stays driven; must be >= COLS+3
DEBOUNCE, 4, consecutive agreeing samples needed to change a key's stable state (>=1)
FIFO_DEPTH, 4, key-code queue entries (power of 2, >=2)

Ports:
clk  in  1  system clock
RST  in  1  asynchronous reset, active-high
col  in  COLS  column sense, active-high, asynchronous to clk
row  out  ROWS  one-hot row strobe
key_state  out  ROWS*COLS  debounced key map, bit r*COLS+c
key_valid  out  1  FIFO non-empty
key_code  out  clog2(ROWS*COLS)  FIFO head, code = r*COLS+c
key_rd  in  1  pop strobe
irq  out  1  equals key_valid
overflow  out  1  sticky, press event dropped because FIFO full
ovf_clr  in  1  clears overflow

Behaviour:
- Interface: one clock `clk`. `RST` is asynchronous and active-high; it clears all state immediately, including mid-scan.
- Reset values:
  - row = 1 (row 0 driven); row index = 0; dwell counter = 0.
  - key_state = 0; all debounce counters = 0.
  - FIFO empty; key_valid = 0; irq = 0; key_code = 0; overflow = 0.
- Column synchroniser: col passes through a 2-flop synchroniser before any use.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1 while row index r is driven.
  - At count SCAN_DIV-1 the counter wraps to 0 and r advances; r wraps from ROWS-1 to 0.
  - row = 1<<r, registered. It changes on the same edge as r.
- Sampling:
  - Column c of row r is evaluated at dwell count SCAN_DIV-COLS+c.
  - At most one key is evaluated per clock. Multiple keys in one row are therefore processed in ascending column order.
- Debounce, per key (stable bit = key_state bit, counter of width clog2(DEBOUNCE+1)):
  - Sample equals stable: counter is cleared.
  - Sample differs from stable: counter increments.
  - When the counter would reach DEBOUNCE: stable flips and the counter is cleared.
  - A key changes state only after DEBOUNCE consecutive visits to its row.
- Events:
  - A 0->1 flip of stable pushes code r*COLS+c.
  - A 1->0 flip (release) updates key_state only; no push.
  - A held key never re-pushes.
- FIFO, first-word fall-through:
  - key_code shows the head whenever key_valid = 1; its value is don't-care when empty.
  - Pop occurs when key_rd && key_valid. key_rd while empty is ignored.
  - Push and pop in the same cycle:
    - Non-empty FIFO: both happen, count unchanged.
    - Empty FIFO: the pushed code appears next cycle.
  - Full FIFO, push without pop: new code dropped, contents kept, overflow set.
  - Full FIFO, push with pop: both happen, no overflow.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Overflow:
  - ovf_clr clears overflow.
  - If ovf_clr and an overflow event occur in the same cycle, overflow = 1 (set wins).
- Latency: a key pressed steadily is visible on key_valid within (DEBOUNCE+1)*ROWS*SCAN_DIV+3 clocks.

Test Plan:
All scenarios use ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=2, FIFO_DEPTH=4. The bench keypad model drives col = mask whenever the matching row bit is high, else 0.
- Reset/scan: assert RST, then release. Required: row=0001, key_valid=0, overflow=0. row then steps 0001->0010->0100->1000->0001, holding each value 8 clocks. RST pulsed mid-dwell returns row to 0001 immediately.
- Single press: hold key r1c0 (col=0001 while row[1]). Required: after the 2nd row-1 visit, key_state bit4=1, key_valid=1, key_code=4, irq=1. One key_rd pulse gives key_valid=0. Holding 10 more scans gives no further push. Releasing clears bit4 after 2 visits, with no push.
- Glitch reject: key r3c2 present for exactly one row-3 visit. Required: key_state stays 0 and key_valid stays 0.
- Same-row pair: keys r2c1 and r2c3 pressed together. Required: pops yield 9 then 11, then key_valid=0.
- Overflow: press and release 5 distinct keys (codes 0,1,2,3,5) with no reads. Required: overflow=1; pops yield 0,1,2,3; code 5 is absent. Then pulse ovf_clr: overflow=0.
- Simultaneous push/pop: FIFO full (4 entries), key_rd asserted in the cycle a new press is pushed. Required: overflow stays 0, count stays 4, new code appears last.
